// File: rtl/rs232_tx_arbiter.sv
// Three-requester round-robin arbiter feeding one RS232 transmit stream.
// A grant is held until an end-of-line word, a burst limit, or a stall timeout.
module rs232_tx_arbiter #(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      BURST   = 64,
  parameter logic [WIDTH-1:0] EOL     = WIDTH'(32'h0000000A),
  parameter int unsigned      TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_0,
  input  logic [WIDTH-1:0] input_1,
  input  logic [WIDTH-1:0] input_2,
  input  logic             input_0_stb,
  input  logic             input_1_stb,
  input  logic             input_2_stb,
  output logic             input_0_ack,
  output logic             input_1_ack,
  output logic             input_2_ack,
  output logic [WIDTH-1:0] output_rs232_tx,
  output logic             output_rs232_tx_stb,
  input  logic             output_rs232_tx_ack,
  output logic [1:0]       grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    SEND   = 2'd2
  } state_e;

  localparam logic [7:0]  BURST_W   = 8'(BURST);
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_e           state_q, state_d;
  logic [1:0]       g_q, g_d;
  logic [1:0]       last_q, last_d;
  logic [7:0]       count_q, count_d;
  logic [15:0]      stall_q, stall_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             out_stb_q, out_stb_d;
  logic [2:0]       ack_q, ack_d;
  logic [1:0]       grant_q, grant_d;
  logic [2:0]       req_s;
  logic [WIDTH-1:0] sel_data_s;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    rr_next = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // First requester found searching last+1, last+2, last+3 (mod 3).
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
    logic [1:0] c1, c2, c3;
    c1 = rr_next(last);
    c2 = rr_next(c1);
    c3 = rr_next(c2);
    rr_pick = req[c1] ? c1 : (req[c2] ? c2 : c3);
  endfunction

  assign req_s = {input_2_stb, input_1_stb, input_0_stb};

  // Data mux for the current owner.
  always_comb begin
    sel_data_s = input_2;
    case (g_q)
      2'd0:    sel_data_s = input_0;
      2'd1:    sel_data_s = input_1;
      default: sel_data_s = input_2;
    endcase
  end

  // Next-state logic; acks and grant are computed from the next state so they come out of flops.
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    last_d    = last_q;
    count_d   = count_q;
    stall_d   = stall_q;
    data_d    = data_q;
    out_stb_d = out_stb_q;
    case (state_q)
      IDLE: begin
        if (|req_s) begin
          g_d     = rr_pick(last_q, req_s);
          state_d = ACCEPT;
        end else begin
          state_d = IDLE;
        end
      end
      ACCEPT: begin
        if (req_s[g_q]) begin
          data_d    = sel_data_s;
          out_stb_d = 1'b1;
          count_d   = count_q + 8'd1;
          stall_d   = 16'd0;
          state_d   = SEND;
        end else if ((stall_q + 16'd1) == TIMEOUT_W) begin
          last_d  = g_q;
          count_d = 8'd0;
          stall_d = 16'd0;
          state_d = IDLE;
        end else begin
          stall_d = stall_q + 16'd1;
        end
      end
      SEND: begin
        if (output_rs232_tx_ack) begin
          out_stb_d = 1'b0;
          if ((data_q == EOL) || (count_q == BURST_W)) begin
            last_d  = g_q;
            count_d = 8'd0;
            state_d = IDLE;
          end else begin
            state_d = ACCEPT;
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        out_stb_d = 1'b0;
        count_d   = 8'd0;
        stall_d   = 16'd0;
        state_d   = IDLE;
      end
    endcase

    ack_d   = 3'b000;
    grant_d = 2'd3;
    if (state_d == ACCEPT) begin
      ack_d = 3'b001 << g_d;
    end else begin
      ack_d = 3'b000;
    end
    if (state_d != IDLE) begin
      grant_d = g_d;
    end else begin
      grant_d = 2'd3;
    end
  end

  // State and output registers; reset drops any word in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      g_q       <= 2'd0;
      last_q    <= 2'd2;
      count_q   <= 8'd0;
      stall_q   <= 16'd0;
      data_q    <= {WIDTH{1'b0}};
      out_stb_q <= 1'b0;
      ack_q     <= 3'b000;
      grant_q   <= 2'd3;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      last_q    <= last_d;
      count_q   <= count_d;
      stall_q   <= stall_d;
      data_q    <= data_d;
      out_stb_q <= out_stb_d;
      ack_q     <= ack_d;
      grant_q   <= grant_d;
    end
  end

  assign input_0_ack         = ack_q[0];
  assign input_1_ack         = ack_q[1];
  assign input_2_ack         = ack_q[2];
  assign output_rs232_tx     = data_q;
  assign output_rs232_tx_stb = out_stb_q;
  assign grant               = grant_q;

endmodule
